// File: rtl/branch_predictor_if.sv
// Fetch/decode connection to the branch target predictor: lookup request,
// registered prediction result, resolved-branch update and table clear.
interface branch_predictor_if #(
    parameter int ADDR_W = 32
);
    logic              lookup_valid;
    logic [ADDR_W-1:0] lookup_pc;
    logic              flush;

    logic              pred_valid;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;

    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;

    logic              clear_req;
    logic              busy;

    modport master (
        output lookup_valid, lookup_pc, flush,
        output upd_valid, upd_pc, upd_taken, upd_target,
        output clear_req,
        input  pred_valid, pred_hit, pred_taken, pred_target,
        input  busy
    );

    modport slave (
        input  lookup_valid, lookup_pc, flush,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        input  clear_req,
        output pred_valid, pred_hit, pred_taken, pred_target,
        output busy
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// one-cycle registered lookup and a one-entry-per-cycle table clear walk.
module branch_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] walk_q, walk_d;

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic [1:0]        ctr_d    [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [ADDR_W-1:0] target_d [ENTRIES];

    logic              pred_valid_q, pred_valid_d;
    logic              pred_hit_q, pred_hit_d;
    logic              pred_taken_q, pred_taken_d;
    logic [ADDR_W-1:0] pred_target_q, pred_target_d;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             upd_en;
    logic             upd_pc_unused;

    assign lk_idx   = bp.lookup_pc[IDX_W+1:2];
    assign lk_tag   = bp.lookup_pc[ADDR_W-1:IDX_W+2];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctr_q[lk_idx][1];

    assign up_idx = bp.upd_pc[IDX_W+1:2];
    assign up_tag = bp.upd_pc[ADDR_W-1:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    // A clear request wins over an update arriving in the same cycle.
    assign upd_en = bp.upd_valid && (state_q == IDLE) && !bp.clear_req;

    assign upd_pc_unused = ^bp.upd_pc[1:0];

    always_comb begin
        state_d = state_q;
        walk_d  = walk_q;
        case (state_q)
            IDLE: begin
                if (bp.clear_req) begin
                    state_d = CLEAR;
                    walk_d  = '0;
                end
            end
            CLEAR: begin
                walk_d = walk_q + IDX_W'(1);
                if (walk_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                walk_d  = '0;
            end
        endcase
    end

    always_comb begin
        pred_valid_d  = bp.lookup_valid && !bp.flush && (state_q == IDLE);
        pred_hit_d    = 1'b0;
        pred_taken_d  = 1'b0;
        pred_target_d = '0;
        if (pred_valid_d) begin
            pred_hit_d    = lk_hit;
            pred_taken_d  = lk_taken;
            pred_target_d = lk_taken ? target_q[lk_idx] : bp.lookup_pc + ADDR_W'(4);
        end
    end

    // Lookups read the pre-edge table, so a same-cycle update is never bypassed.
    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (state_q == CLEAR) begin
            valid_d[walk_q] = 1'b0;
        end else if (upd_en) begin
            if (up_hit) begin
                if (bp.upd_taken) begin
                    if (ctr_q[up_idx] != 2'd3) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    end
                    target_d[up_idx] = bp.upd_target;
                end else if (ctr_q[up_idx] != 2'd0) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bp.upd_target;
                ctr_d[up_idx]    = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            walk_q        <= '0;
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'd1;
            end
        end else begin
            state_q       <= state_d;
            walk_q        <= walk_d;
            pred_valid_q  <= pred_valid_d;
            pred_hit_q    <= pred_hit_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= valid_d[i];
                ctr_q[i]   <= ctr_d[i];
            end
        end
    end

    // Tags and targets are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= tag_d[i];
            target_q[i] <= target_d[i];
        end
    end

    assign bp.pred_valid  = pred_valid_q;
    assign bp.pred_hit    = pred_hit_q;
    assign bp.pred_taken  = pred_taken_q;
    assign bp.pred_target = pred_target_q;
    assign bp.busy        = (state_q == CLEAR);
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: lookups push their expected prediction, a negedge monitor
// pops and compares whenever the predictor presents pred_valid.
module tb_branch_predictor;
    localparam int ADDR_W  = 32;
    localparam int ENTRIES = 16;

    typedef struct {
        int          cyc;
        logic        hit;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    branch_predictor_if #(.ADDR_W(ADDR_W)) bp();

    branch_predictor #(
        .ADDR_W (ADDR_W),
        .ENTRIES(ENTRIES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp (bp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic idle_inputs();
        bp.lookup_valid = 1'b0;
        bp.lookup_pc    = '0;
        bp.flush        = 1'b0;
        bp.upd_valid    = 1'b0;
        bp.upd_pc       = '0;
        bp.upd_taken    = 1'b0;
        bp.upd_target   = '0;
        bp.clear_req    = 1'b0;
    endtask

    // Advance one clock and return inputs to idle, one time unit after the edge.
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic drive_lookup(input logic [31:0] pc, input logic hit, input logic taken, input logic [31:0] tgt);
        bp.lookup_valid = 1'b1;
        bp.lookup_pc    = pc;
        exp_q.push_back('{cyc + 1, hit, taken, tgt});
    endtask

    task automatic drive_killed(input logic [31:0] pc, input logic fl);
        bp.lookup_valid = 1'b1;
        bp.lookup_pc    = pc;
        bp.flush        = fl;
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        bp.upd_valid  = 1'b1;
        bp.upd_pc     = pc;
        bp.upd_taken  = taken;
        bp.upd_target = tgt;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("[TB] FAIL missing_pred actual=pred_valid 0 required=pred_valid 1 for cycle %0d", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (bp.pred_valid) begin
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pred actual=pred_valid 1 required=pred_valid 0 (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check_output("pred_hit", 32'(bp.pred_hit), 32'(e.hit));
                check_output("pred_taken", 32'(bp.pred_taken), 32'(e.taken));
                check_output("pred_target", bp.pred_target, e.target);
            end
        end else begin
            check_output("idle_outputs_zero",
                         32'(bp.pred_hit || bp.pred_taken || (bp.pred_target != '0)), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_busy", 32'(bp.busy), 32'd0);
        check_output("reset_pred_valid", 32'(bp.pred_valid), 32'd0);

        // First lookup on the first edge after reset release
        rst = 1'b1;
        drive_lookup(32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044); apply_stimulus();

        // Allocate, then weaken to not-taken
        drive_update(32'h40, 1'b1, 32'h100); apply_stimulus();
        drive_lookup(32'h40, 1'b1, 1'b1, 32'h100); apply_stimulus();
        drive_update(32'h40, 1'b0, 32'h0); apply_stimulus();
        drive_update(32'h40, 1'b0, 32'h0); apply_stimulus();
        drive_lookup(32'h40, 1'b1, 1'b0, 32'h44); apply_stimulus();

        // Counter 0 -> 3 with saturation, then step down
        repeat (4) begin
            drive_update(32'h40, 1'b1, 32'h100); apply_stimulus();
        end
        drive_lookup(32'h40, 1'b1, 1'b1, 32'h100); apply_stimulus();
        drive_update(32'h40, 1'b0, 32'h999); apply_stimulus();
        drive_lookup(32'h40, 1'b1, 1'b1, 32'h100); apply_stimulus();
        drive_update(32'h40, 1'b0, 32'h0); apply_stimulus();
        drive_lookup(32'h40, 1'b1, 1'b0, 32'h44); apply_stimulus();

        // Aliasing on index 0
        drive_lookup(32'h440, 1'b0, 1'b0, 32'h444); apply_stimulus();
        drive_update(32'h440, 1'b1, 32'h200); apply_stimulus();
        drive_lookup(32'h40, 1'b0, 1'b0, 32'h44); apply_stimulus();
        drive_lookup(32'h440, 1'b1, 1'b1, 32'h200); apply_stimulus();

        // Same-cycle lookup and allocating update: no bypass
        drive_lookup(32'h80, 1'b0, 1'b0, 32'h84);
        drive_update(32'h80, 1'b1, 32'h300); apply_stimulus();
        drive_lookup(32'h80, 1'b1, 1'b1, 32'h300); apply_stimulus();

        // Not-taken misses leave the table alone
        drive_update(32'h40, 1'b0, 32'h777); apply_stimulus();
        drive_lookup(32'h80, 1'b1, 1'b1, 32'h300); apply_stimulus();
        drive_update(32'h1C4, 1'b0, 32'h888); apply_stimulus();
        drive_lookup(32'h1C4, 1'b0, 1'b0, 32'h1C8); apply_stimulus();

        // Flush kills the lookup
        drive_killed(32'h80, 1'b1); apply_stimulus();
        drive_lookup(32'h80, 1'b1, 1'b1, 32'h300); apply_stimulus();

        // Fall-through address wraps
        drive_lookup(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0); apply_stimulus();

        drive_update(32'h44, 1'b1, 32'h500); apply_stimulus();
        drive_lookup(32'h44, 1'b1, 1'b1, 32'h500); apply_stimulus();

        // Clear walk with a coincident (dropped) update
        bp.clear_req = 1'b1;
        drive_update(32'h48, 1'b1, 32'h600); apply_stimulus();
        for (int i = 0; i < ENTRIES; i++) begin
            check_output("busy_during_clear", 32'(bp.busy), 32'd1);
            drive_killed(32'h80, 1'b0);
            if (i == 3) bp.clear_req = 1'b1;
            if (i == ENTRIES - 1) drive_update(32'h44, 1'b1, 32'h500);
            apply_stimulus();
        end
        check_output("busy_after_clear", 32'(bp.busy), 32'd0);
        drive_lookup(32'h80, 1'b0, 1'b0, 32'h84); apply_stimulus();
        drive_lookup(32'h44, 1'b0, 1'b0, 32'h48); apply_stimulus();
        drive_lookup(32'h48, 1'b0, 1'b0, 32'h4C); apply_stimulus();
        drive_lookup(32'h440, 1'b0, 1'b0, 32'h444); apply_stimulus();

        // Reset in the fifth cycle of a clear walk
        drive_update(32'h7C, 1'b1, 32'h700); apply_stimulus();
        drive_lookup(32'h7C, 1'b1, 1'b1, 32'h700); apply_stimulus();
        bp.clear_req = 1'b1; apply_stimulus();
        repeat (4) begin
            check_output("busy_before_abort", 32'(bp.busy), 32'd1);
            apply_stimulus();
        end
        check_output("busy_before_abort", 32'(bp.busy), 32'd1);
        rst = 1'b0;
        #1;
        check_output("busy_async_reset", 32'(bp.busy), 32'd0);
        check_output("pred_valid_async_reset", 32'(bp.pred_valid), 32'd0);
        apply_stimulus();
        apply_stimulus();
        rst = 1'b1;
        drive_lookup(32'h7C, 1'b0, 1'b0, 32'h80); apply_stimulus();
        drive_lookup(32'h80, 1'b0, 1'b0, 32'h84); apply_stimulus();
        check_output("busy_after_reset", 32'(bp.busy), 32'd0);

        apply_stimulus();
        apply_stimulus();
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning instruction address width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning table depth; a power of two, 2..256.
REQ-003 SHALL have derived localparam IDX_W = log2(ENTRIES) and TAG_W = ADDR_W-IDX_W-2.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port lookup_valid  in  1  fetch-stage lookup request.
REQ-007 SHALL have port lookup_pc  in  ADDR_W  address being fetched.
REQ-008 SHALL have port flush  in  1  kills the lookup registered this cycle.
REQ-009 SHALL have port pred_valid  out  1  prediction result valid.
REQ-010 SHALL have port pred_hit  out  1  table entry matched.
REQ-011 SHALL have port pred_taken  out  1  predicted taken.
REQ-012 SHALL have port pred_target  out  ADDR_W  predicted next fetch address.
REQ-013 SHALL have port upd_valid  in  1  resolved-branch update from decode.
REQ-014 SHALL have port upd_pc  in  ADDR_W  address of resolved branch/jump.
REQ-015 SHALL have port upd_taken  in  1  resolved direction.
REQ-016 SHALL have port upd_target  in  ADDR_W  resolved target address.
REQ-017 SHALL have port clear_req  in  1  single-cycle request to invalidate the whole table.
REQ-018 SHALL have port busy  out  1  high while the clear walk is in progress.

Function
REQ-019 SHALL hold per entry: valid bit, TAG_W tag, ADDR_W target, 2-bit saturating counter.
REQ-020 SHALL use index = pc[IDX_W+1:2] and tag = pc[ADDR_W-1:IDX_W+2] for both lookup and update.
REQ-021 SHALL register lookups with latency 1: pred_valid in cycle N+1 = lookup_valid && !flush && !busy, all sampled in cycle N.
REQ-022 SHALL set pred_hit = entry valid && tag equal; pred_taken = pred_hit && counter[1]; pred_target = stored target when pred_taken, else lookup_pc+4, modulo 2^ADDR_W.
REQ-023 SHALL hold pred_hit, pred_taken and pred_target at 0 in any cycle where pred_valid is 0.
REQ-024 On update hit, SHALL increment the counter when taken (saturating at 3) and decrement it when not taken (saturating at 0).
REQ-025 On update hit with upd_taken=1, SHALL overwrite the stored target with upd_target; on a not-taken hit the target is unchanged.
REQ-026 On update miss with upd_taken=1, SHALL allocate (overwrite) the indexed entry: valid=1, new tag, target=upd_target, counter=2.
REQ-027 On update miss with upd_taken=0, SHALL leave the table unchanged.
REQ-028 When an update and a lookup address the same index in the same cycle, the lookup SHALL see table contents from before that edge; there is no bypass.
REQ-029 SHALL implement an FSM with states IDLE and CLEAR.
REQ-030 On clear_req in IDLE, SHALL go to CLEAR, zeroing a walk counter.
REQ-031 In CLEAR, SHALL invalidate entry[walk] each cycle and increment walk.
REQ-032 SHALL return to IDLE after the cycle that clears entry ENTRIES-1; CLEAR lasts exactly ENTRIES cycles.
REQ-033 busy SHALL be 1 exactly while in CLEAR.
REQ-034 In CLEAR, SHALL ignore updates and clear_req, and suppress pred_valid per REQ-021.
REQ-035 An update coincident with clear_req in IDLE SHALL be dropped.

Reset
REQ-036 While rst=0, asynchronously: state=IDLE, walk=0, all valid bits=0, all counters=1, pred_valid/pred_hit/pred_taken/pred_target=0, busy=0.
REQ-037 Target and tag storage need no reset.
REQ-038 Reset asserted mid-CLEAR SHALL abort the walk; the table is fully invalid on release.
REQ-039 The first lookup SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-040 Post-reset lookup 0x0000_0040 -> next cycle pred_valid=1, hit=0, taken=0, target=0x0000_0044.
REQ-041 Update pc=0x40, taken, target=0x100; then lookup 0x40 -> hit=1, taken=1, target=0x100; two not-taken updates -> taken=0, target=0x44.
REQ-042 Four taken updates to the same pc -> counter saturates at 3; one not-taken update -> still predicts taken.
REQ-043 Aliasing (ENTRIES=16): update 0x40 taken, then lookup 0x440 (same index, different tag) -> hit=0; taken update to 0x440 evicts 0x40.
REQ-044 Same-cycle lookup and allocating update to 0x80 -> that lookup reports hit=0; the next lookup reports hit=1.
REQ-045 clear_req -> busy=1 for 16 cycles, lookups give pred_valid=0; afterwards all lookups miss; rst pulse at cycle 5 of CLEAR -> busy=0 immediately.
